// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI slave receiver.
package spi_pkg;

  localparam int SPI_DATA_W      = 8;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_slave_rx_sync_edge.sv
// Module sync_edge: N-stage synchroniser for one asynchronous pin, followed by
// a history flop that yields single-cycle rise/fall strobes.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // NOTE: every flop in a clocked block uses <=, so each stage samples the
  // value its neighbour held before this edge and the chain really is STAGES deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slave_rx.sv
// Oversampled SPI mode-0 slave receiver, MSB first, one-cycle done per word.
// Define SPI_SLAVE_RX_TX_EN to enable the MISO transmit path.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              busy,
  output logic              frame_err
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_mosi_sync;
  logic w_sck_sync, w_cs_sync, w_mosi_rise, w_mosi_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .i_async(sck),
    .o_sync(w_sck_sync), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .i_async(cs_n),
    .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_async(mosi),
    .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_inc, w_bit_cnt_post;
  logic [DATA_W-1:0]  r_shreg, r_data_out;
  logic               r_done, r_frame_err, w_busy;
  logic               w_last_bit, w_shift_en, w_word_done, w_cs_end, w_start;

  assign w_last_bit     = (r_bit_cnt == LAST_BIT);
  assign w_bit_cnt_inc  = w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
  assign w_start        = (r_state == IDLE) && w_cs_fall;
  assign w_shift_en     = (r_state == SHIFT) && w_sck_rise;
  assign w_word_done    = w_shift_en && w_last_bit;
  assign w_cs_end       = (r_state == SHIFT) && w_cs_rise;
  // A coincident sck_rise is counted before the CS_N rise is judged.
  assign w_bit_cnt_post = w_shift_en ? w_bit_cnt_inc : r_bit_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (w_cs_rise) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: the shift and data registers are ordinary flops rather than a RAM
  // array, so they take the reset too and data_out is defined from reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_data_out  <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_done      <= w_word_done;
      r_frame_err <= w_cs_end && (w_bit_cnt_post != '0);
      if (w_start)         r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= w_bit_cnt_inc;
      if (w_shift_en)  r_shreg    <= {r_shreg[DATA_W-2:0], w_mosi_sync};
      if (w_word_done) r_data_out <= {r_shreg[DATA_W-2:0], w_mosi_sync};
    end
  end

  assign data_out  = r_data_out;
  assign done      = r_done;
  assign busy      = w_busy;
  assign frame_err = r_frame_err;

`ifdef SPI_SLAVE_RX_TX_EN
  logic [DATA_W-1:0] r_tx_hold, r_tx_shreg;
  logic              w_tx_reload;
  logic              w_unused;

  assign w_tx_reload = w_start || w_word_done;
  assign w_unused    = ^{w_sck_sync, w_cs_sync, w_mosi_rise, w_mosi_fall};

  // The fall after a word boundary is skipped (bit_cnt==0) so the freshly
  // loaded MSB survives until the master samples it on the next rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_hold  <= '0;
      r_tx_shreg <= '0;
    end else if (w_tx_reload) begin
      r_tx_shreg <= tx_load ? tx_data : r_tx_hold;
      r_tx_hold  <= '0;
    end else begin
      if (tx_load) r_tx_hold <= tx_data;
      if ((r_state == SHIFT) && w_sck_fall && (r_bit_cnt != '0))
        r_tx_shreg <= {r_tx_shreg[DATA_W-2:0], 1'b0};
    end
  end

  assign miso = w_busy ? r_tx_shreg[DATA_W-1] : 1'b0;
`else
  logic w_unused;

  assign w_unused = ^{w_sck_sync, w_cs_sync, w_mosi_rise, w_mosi_fall,
                      w_sck_fall, tx_data, tx_load};
  assign miso     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: table of words plus hand-written corner sequences.
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst, sck, cs_n, mosi, tx_load;
  logic [7:0] tx_data;
  logic       miso, done, busy, frame_err;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int dbl_cnt  = 0;
  bit prev_done = 1'b0;

  always #5 clk = ~clk;

  spi_slave_rx dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .data_out(data_out), .done(done),
    .busy(busy), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if ((done === 1'b1) && prev_done) dbl_cnt++;
    prev_done = (done === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SCK = clk/8: mosi changes with each falling edge, master samples miso just before each rise.
  task automatic send_word(input logic [7:0] d, input int nbits, input bit cs_with_last,
                           output logic [7:0] miso_rx);
    miso_rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = d[7-i];
      repeat (4) @(negedge clk);
      miso_rx = {miso_rx[6:0], miso};
      sck = 1'b1;
      if (cs_with_last && (i == nbits - 1)) cs_n = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    mosi = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    int         nbits;
    bit         end_frame;
    int         exp_done;
    logic [7:0] exp_data;
    int         exp_err;
    bit         exp_busy;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [7:0] rx;
    bit         open;
    int         d0, e0;

    vecs[0] = '{8'h77, 8, 1'b1, 1, 8'h77, 0, 1'b0};
    vecs[1] = '{8'h01, 8, 1'b0, 1, 8'h01, 0, 1'b1};
    vecs[2] = '{8'h23, 8, 1'b0, 1, 8'h23, 0, 1'b1};
    vecs[3] = '{8'h00, 8, 1'b0, 1, 8'h00, 0, 1'b1};
    vecs[4] = '{8'hAA, 8, 1'b1, 1, 8'hAA, 0, 1'b0};
    vecs[5] = '{8'hAA, 3, 1'b1, 0, 8'hAA, 1, 1'b0};
    vecs[6] = '{8'h55, 8, 1'b1, 1, 8'h55, 0, 1'b0};
    vecs[7] = '{8'hC3, 8, 1'b0, 1, 8'hC3, 0, 1'b1};
    vecs[8] = '{8'hFF, 8, 1'b1, 1, 8'hFF, 0, 1'b0};

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;

    // Reset held for 10 clocks with SCK toggling.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sck = ~sck;
    end
    check("rst data_out", data_out, 8'h00);
    check("rst done", done, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst frame_err", frame_err, 1'b0);
    check("rst miso", miso, 1'b0);
    check("rst done count", done_cnt, 0);
    sck = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    open = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (!open) begin
        cs_n = 1'b0;
        open = 1'b1;
      end
      d0 = done_cnt;
      e0 = err_cnt;
      send_word(vecs[i].data, vecs[i].nbits, 1'b0, rx);
      repeat (4) @(negedge clk);
      if (vecs[i].end_frame) begin
        cs_n = 1'b1;
        open = 1'b0;
        repeat (8) @(negedge clk);
      end
      check($sformatf("v%0d done", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("v%0d data_out", i), data_out, vecs[i].exp_data);
      check($sformatf("v%0d frame_err", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("v%0d busy", i), busy, vecs[i].exp_busy);
    end

    // Last SCK rise and CS_N rise on the same instant: word completes, no error.
    d0 = done_cnt; e0 = err_cnt;
    cs_n = 1'b0;
    send_word(8'h96, 8, 1'b1, rx);
    repeat (8) @(negedge clk);
    check("simul done", done_cnt - d0, 1);
    check("simul data_out", data_out, 8'h96);
    check("simul frame_err", err_cnt - e0, 0);
    check("simul busy", busy, 1'b0);

    // Same coincidence on bit 3: post-increment count is nonzero, so error.
    d0 = done_cnt; e0 = err_cnt;
    cs_n = 1'b0;
    send_word(8'hE0, 3, 1'b1, rx);
    repeat (8) @(negedge clk);
    check("simul partial done", done_cnt - d0, 0);
    check("simul partial frame_err", err_cnt - e0, 1);
    check("simul partial data_out", data_out, 8'h96);

    // Transmit path: 0xA5 loaded before CS_N falls, then a word with nothing loaded.
    @(negedge clk);
    tx_data = 8'hA5; tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0; tx_data = 8'h00;
    repeat (2) @(negedge clk);
    cs_n = 1'b0;
    send_word(8'h5A, 8, 1'b0, rx);
`ifdef SPI_SLAVE_RX_TX_EN
    check("tx word0 miso", rx, 8'hA5);
`else
    check("tx word0 miso", rx, 8'h00);
`endif
    repeat (4) @(negedge clk);
    check("tx word0 data_out", data_out, 8'h5A);
    send_word(8'h3C, 8, 1'b0, rx);
    check("tx word1 miso", rx, 8'h00);
    repeat (4) @(negedge clk);
    check("tx word1 data_out", data_out, 8'h3C);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);

    // Reset after 4 bits with CS_N still low, then a clean realigned frame.
    cs_n = 1'b0;
    send_word(8'hF0, 4, 1'b0, rx);
    rst = 1'b1;
    @(negedge clk);
    check("midrst data_out", data_out, 8'h00);
    check("midrst busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst resync busy", busy, 1'b1);
    e0 = err_cnt;
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst realign busy", busy, 1'b0);
    check("midrst realign frame_err", err_cnt - e0, 0);
    d0 = done_cnt;
    cs_n = 1'b0;
    send_word(8'h01, 8, 1'b0, rx);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst done", done_cnt - d0, 1);
    check("midrst data_out", data_out, 8'h01);
    check("midrst frame_err", err_cnt - e0, 0);

    check("no back-to-back done", dbl_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
